// File: rtl/pipeline_mem_responder.sv
// Arbitrates level-held imem/dmem requests onto one single-ported memory, one access outstanding.
// Latency: grant in IDLE, mem_* next cycle, *_resp pulse the cycle after mem_resp (min 2 cycles).
// Backpressure: requesters hold until *_resp; the losing side simply waits in IDLE arbitration.
module pipeline_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter bit DMEM_PRIO  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    imem_read,
    input  logic [ADDR_WIDTH-1:0]   imem_address,
    output logic [DATA_WIDTH-1:0]   imem_rdata,
    output logic                    imem_resp,
    input  logic                    dmem_read,
    input  logic                    dmem_write,
    input  logic [ADDR_WIDTH-1:0]   dmem_address,
    input  logic [DATA_WIDTH/8-1:0] dmem_wmask,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata,
    output logic [DATA_WIDTH-1:0]   dmem_rdata,
    output logic                    dmem_resp,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_resp
);

    localparam int MW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [MW-1:0]           lat_mask;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic                    lat_write;
    logic                    served_d;
    logic                    last_d;
    logic                    drop;
    logic                    imem_req;
    logic                    dmem_req;
    logic                    grant_d;
    logic                    busy;

    assign imem_req = imem_read;
    assign dmem_req = dmem_read | dmem_write;

    // Without priority, a tie goes to whichever side did not win last time.
    always_comb begin
        grant_d = 1'b0;
        if (dmem_req && !imem_req)
            grant_d = 1'b1;
        else if (dmem_req && imem_req)
            grant_d = DMEM_PRIO ? 1'b1 : !last_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (imem_req || dmem_req) state_nxt = grant_d ? BUSY_D : BUSY_I;
            BUSY_I: if (mem_resp) state_nxt = RESP;
            BUSY_D: if (mem_resp) state_nxt = RESP;
            RESP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == BUSY_I) || (state == BUSY_D);
        mem_read  = busy && !lat_write;
        mem_write = busy && lat_write;
        imem_resp = (state == RESP) && !served_d && !drop;
        dmem_resp = (state == RESP) && served_d && !drop;
    end

    assign mem_address = lat_addr;
    assign mem_wmask   = lat_mask;
    assign mem_wdata   = lat_wdata;

    // Memory is driven only from these latches, so requesters may change inputs while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr   <= '0;
            lat_mask   <= '0;
            lat_wdata  <= '0;
            lat_write  <= 1'b0;
            served_d   <= 1'b0;
            last_d     <= 1'b1;
            drop       <= 1'b0;
            imem_rdata <= '0;
            dmem_rdata <= '0;
        end else begin
            if (state == IDLE && (imem_req || dmem_req)) begin
                lat_addr  <= grant_d ? dmem_address : imem_address;
                lat_write <= grant_d && dmem_write;
                lat_mask  <= (grant_d && dmem_write) ? dmem_wmask : '0;
                lat_wdata <= (grant_d && dmem_write) ? dmem_wdata : '0;
                served_d  <= grant_d;
                last_d    <= grant_d;
                drop      <= 1'b0;
            end
            // A flushed requester still lets the access finish; only its pulse is suppressed.
            if ((state == BUSY_I && !imem_req) || (state == BUSY_D && !dmem_req))
                drop <= 1'b1;
            if (busy && mem_resp && !lat_write) begin
                if (served_d)
                    dmem_rdata <= mem_rdata;
                else
                    imem_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_mem_responder.sv
// Directed bench for pipeline_mem_responder with DMEM_PRIO=1 and a hand-driven memory.
module tb_pipeline_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_read = 1'b0;
    logic [31:0] imem_address = '0;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        dmem_read = 1'b0;
    logic        dmem_write = 1'b0;
    logic [31:0] dmem_address = '0;
    logic [3:0]  dmem_wmask = '0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;

    int checks = 0;
    int errors = 0;

    pipeline_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DMEM_PRIO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_read(imem_read), .imem_address(imem_address),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #3;
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk1("rst_imem_resp", imem_resp, 1'b0);
        chk1("rst_dmem_resp", dmem_resp, 1'b0);
        chk32("rst_imem_rdata", imem_rdata, 32'h0);
        chk32("rst_dmem_rdata", dmem_rdata, 32'h0);
        chk32("rst_mem_address", mem_address, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // 1: lone fetch, memory answers at once
        imem_read = 1'b1; imem_address = 32'h60;
        step();
        chk1("t1_mem_read", mem_read, 1'b1);
        chk32("t1_mem_addr", mem_address, 32'h60);
        chk32("t1_mem_wmask", 32'(mem_wmask), 32'h0);
        chk1("t1_no_resp_yet", imem_resp, 1'b0);
        mem_resp = 1'b1; mem_rdata = 32'h00000013;
        step();
        chk1("t1_imem_resp", imem_resp, 1'b1);
        chk32("t1_imem_rdata", imem_rdata, 32'h13);
        chk1("t1_no_dmem_resp", dmem_resp, 1'b0);
        chk1("t1_mem_read_off", mem_read, 1'b0);
        mem_resp = 1'b0; imem_read = 1'b0;
        step();
        chk1("t1_idle_resp", imem_resp, 1'b0);

        // 2: simultaneous requests, dmem first
        imem_read = 1'b1; imem_address = 32'h200;
        dmem_read = 1'b1; dmem_address = 32'h300;
        step();
        chk1("t2_d_mem_read", mem_read, 1'b1);
        chk32("t2_d_addr", mem_address, 32'h300);
        mem_resp = 1'b1; mem_rdata = 32'hAAAA0001;
        step();
        chk1("t2_dmem_resp", dmem_resp, 1'b1);
        chk1("t2_no_imem_resp", imem_resp, 1'b0);
        chk32("t2_dmem_rdata", dmem_rdata, 32'hAAAA0001);
        dmem_read = 1'b0; mem_resp = 1'b0;
        step();
        chk1("t2_idle_mem_read", mem_read, 1'b0);
        chk1("t2_idle_dmem_resp", dmem_resp, 1'b0);
        step();
        chk1("t2_i_mem_read", mem_read, 1'b1);
        chk32("t2_i_addr", mem_address, 32'h200);
        mem_resp = 1'b1; mem_rdata = 32'hBBBB0002;
        step();
        chk1("t2_imem_resp", imem_resp, 1'b1);
        chk1("t2_no_dmem_resp2", dmem_resp, 1'b0);
        chk32("t2_imem_rdata", imem_rdata, 32'hBBBB0002);
        imem_read = 1'b0; mem_resp = 1'b0;
        step();

        // 3: store with 3-cycle memory wait; inputs change while busy
        dmem_write = 1'b1; dmem_address = 32'h100; dmem_wmask = 4'b0011; dmem_wdata = 32'hDEADBEEF;
        step();
        dmem_address = 32'h999; dmem_wdata = 32'h0; dmem_wmask = 4'b1111;
        chk1("t3_mem_write_c1", mem_write, 1'b1);
        chk1("t3_no_mem_read", mem_read, 1'b0);
        chk32("t3_wmask", 32'(mem_wmask), 32'h3);
        chk32("t3_wdata", mem_wdata, 32'hDEADBEEF);
        step();
        chk1("t3_mem_write_c2", mem_write, 1'b1);
        chk32("t3_addr_held", mem_address, 32'h100);
        step();
        chk1("t3_mem_write_c3", mem_write, 1'b1);
        chk1("t3_no_early_resp", dmem_resp, 1'b0);
        mem_resp = 1'b1; mem_rdata = 32'h12345678;
        step();
        chk1("t3_dmem_resp", dmem_resp, 1'b1);
        chk1("t3_mem_write_off", mem_write, 1'b0);
        chk32("t3_rdata_kept", dmem_rdata, 32'hAAAA0001);
        dmem_write = 1'b0; mem_resp = 1'b0;
        step();
        chk1("t3_single_pulse", dmem_resp, 1'b0);

        // 4: fetch flushed while busy
        imem_read = 1'b1; imem_address = 32'h400;
        step();
        chk1("t4_mem_read", mem_read, 1'b1);
        imem_read = 1'b0;
        step();
        chk1("t4_access_continues", mem_read, 1'b1);
        mem_resp = 1'b1; mem_rdata = 32'h55;
        step();
        chk1("t4_no_imem_resp", imem_resp, 1'b0);
        chk1("t4_no_dmem_resp", dmem_resp, 1'b0);
        chk1("t4_mem_read_off", mem_read, 1'b0);
        mem_resp = 1'b0;
        step();
        chk1("t4_idle", mem_read, 1'b0);
        imem_read = 1'b1; imem_address = 32'h404;
        step();
        chk1("t4_next_mem_read", mem_read, 1'b1);
        chk32("t4_next_addr", mem_address, 32'h404);
        mem_resp = 1'b1; mem_rdata = 32'h66;
        step();
        chk1("t4_next_resp", imem_resp, 1'b1);
        chk32("t4_next_rdata", imem_rdata, 32'h66);

        // 5: fetch held through RESP becomes a second transaction
        mem_resp = 1'b0;
        step();
        chk1("t5_gap_resp", imem_resp, 1'b0);
        chk1("t5_gap_mem_read", mem_read, 1'b0);
        step();
        chk1("t5_refetch", mem_read, 1'b1);
        chk32("t5_refetch_addr", mem_address, 32'h404);
        mem_resp = 1'b1; mem_rdata = 32'h77;
        step();
        chk1("t5_second_resp", imem_resp, 1'b1);
        chk32("t5_second_rdata", imem_rdata, 32'h77);
        imem_read = 1'b0; mem_resp = 1'b0;
        step();
        chk1("t5_no_third", imem_resp, 1'b0);

        // 6: reset in the middle of a memory wait
        imem_read = 1'b1; imem_address = 32'h500;
        step();
        step();
        chk1("t6_waiting", mem_read, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("t6_rst_mem_read", mem_read, 1'b0);
        chk1("t6_rst_imem_resp", imem_resp, 1'b0);
        chk1("t6_rst_dmem_resp", dmem_resp, 1'b0);
        chk32("t6_rst_imem_rdata", imem_rdata, 32'h0);
        imem_read = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk1("t6_idle_after", mem_read, 1'b0);
        imem_read = 1'b1; imem_address = 32'h600;
        step();
        chk1("t6_new_mem_read", mem_read, 1'b1);
        chk32("t6_new_addr", mem_address, 32'h600);
        mem_resp = 1'b1; mem_rdata = 32'h88;
        step();
        chk1("t6_new_resp", imem_resp, 1'b1);
        chk32("t6_new_rdata", imem_rdata, 32'h88);
        imem_read = 1'b0; mem_resp = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
